// File: rtl/compressor_pwm_if.sv
// Bundle between the thermal PID loop and the compressor PWM driver.
// The master supplies demand and enable; the slave reports the drive state.
interface compressor_pwm_if;
    logic               enable;
    logic signed [15:0] pid_out;
    logic               pid_valid;
    logic               comp_on;
    logic [7:0]         duty;
    logic [1:0]         state;

    modport master (
        output enable, pid_out, pid_valid,
        input  comp_on, duty, state
    );

    modport slave (
        input  enable, pid_out, pid_valid,
        output comp_on, duty, state
    );
endinterface

// File: rtl/compressor_pwm_driver.sv
// Compressor PWM driver: converts cooling demand to a duty cycle and drives the
// compressor through a min-on / min-off protection state machine.
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE_OFF | compressor off, waiting for a PWM request
// MIN_ON   | compressor on, min-on timer running, request ignored
// RUN_ON   | compressor on, follows the PWM request
// MIN_OFF  | compressor off, min-off timer running, request ignored
module compressor_pwm_driver #(
    parameter int unsigned PRESCALE    = 4,
    parameter int unsigned MIN_ON_CYC  = 16,
    parameter int unsigned MIN_OFF_CYC = 32
) (
    input logic             clk,
    input logic             rst,
    compressor_pwm_if.slave bus
);
    localparam int unsigned     PRE_W        = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST    = PRE_W'(PRESCALE - 1);
    localparam logic [15:0]     MIN_ON_LOAD  = 16'(MIN_ON_CYC - 1);
    localparam logic [15:0]     MIN_OFF_LOAD = 16'(MIN_OFF_CYC - 1);

    typedef enum logic [1:0] {
        IDLE_OFF = 2'd0,
        MIN_ON   = 2'd1,
        RUN_ON   = 2'd2,
        MIN_OFF  = 2'd3
    } state_t;

    logic [PRE_W-1:0] pre_cnt;
    logic [7:0]       tick_cnt;
    logic [7:0]       duty_pend;
    logic [7:0]       duty_active;
    logic [15:0]      timer;
    state_t           state_r;
    logic             comp_on_r;

    logic [16:0] pid_ext;
    logic [16:0] pid_mag;
    logic [16:0] mag_shr;
    logic [7:0]  duty_calc;
    logic        pre_wrap;
    logic        period_end;
    logic        pwm_req;
    logic        timer_tc;

    // 17-bit magnitude so that -32768 does not overflow before saturation.
    always_comb begin
        pid_ext   = {bus.pid_out[15], bus.pid_out};
        pid_mag   = -pid_ext;
        mag_shr   = pid_mag >> 3;
        duty_calc = 8'd0;
        if (bus.pid_out[15]) begin
            duty_calc = (mag_shr > 17'd255) ? 8'hFF : mag_shr[7:0];
        end
    end

    assign pre_wrap   = (pre_cnt == PRE_LAST);
    assign period_end = pre_wrap && (tick_cnt == 8'hFF);
    assign pwm_req    = bus.enable && (tick_cnt < duty_active);
    assign timer_tc   = (timer == 16'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_cnt     <= '0;
            tick_cnt    <= 8'd0;
            duty_pend   <= 8'd0;
            duty_active <= 8'd0;
        end else begin
            if (pre_wrap) begin
                pre_cnt  <= '0;
                tick_cnt <= tick_cnt + 8'd1;
            end else begin
                pre_cnt <= pre_cnt + 1'b1;
            end
            // duty_active samples the old duty_pend, so a strobe in the
            // boundary cycle lands one period later.
            if (period_end) begin
                duty_active <= duty_pend;
            end
            if (bus.pid_valid) begin
                duty_pend <= duty_calc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE_OFF;
            timer     <= 16'd0;
            comp_on_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE_OFF: begin
                    if (pwm_req) begin
                        state_r   <= MIN_ON;
                        timer     <= MIN_ON_LOAD;
                        comp_on_r <= 1'b1;
                    end
                end
                MIN_ON: begin
                    if (timer_tc) begin
                        state_r <= RUN_ON;
                    end else begin
                        timer <= timer - 16'd1;
                    end
                end
                RUN_ON: begin
                    if (!pwm_req) begin
                        state_r   <= MIN_OFF;
                        timer     <= MIN_OFF_LOAD;
                        comp_on_r <= 1'b0;
                    end
                end
                MIN_OFF: begin
                    if (timer_tc) begin
                        state_r <= IDLE_OFF;
                    end else begin
                        timer <= timer - 16'd1;
                    end
                end
                default: begin
                    state_r   <= IDLE_OFF;
                    timer     <= 16'd0;
                    comp_on_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.comp_on = comp_on_r;
    assign bus.duty    = duty_active;
    assign bus.state   = state_r;
endmodule

// File: doc/compressor_pwm_driver.md
COMPRESSOR_PWM_DRIVER -- requirements
Module: compressor_pwm_driver

Interface
REQ-001 Parameter: PRESCALE, 4, clk cycles per PWM tick (>=1).
REQ-002 Parameter: MIN_ON_CYC, 16, minimum compressor on-time in clk cycles (1..65535).
REQ-003 Parameter: MIN_OFF_CYC, 32, minimum compressor off-time in clk cycles (1..65535).
REQ-004 Port: clk  input  1  system clock; all state changes on posedge clk.
REQ-005 Port: rst  input  1  reset; one clock, synchronous, active-high.
REQ-006 Port: enable  input  1  drive enable; low forces the PWM request to 0.
REQ-007 Port: pid_out  input  16  signed Q8.8 PID controller output; negative means cooling demand.
REQ-008 Port: pid_valid  input  1  one-cycle strobe qualifying pid_out.
REQ-009 Port: comp_on  output  1  registered compressor drive.
REQ-010 Port: duty  output  8  duty value currently applied (duty_active).
REQ-011 Port: state  output  2  FSM state: 0 IDLE_OFF, 1 MIN_ON, 2 RUN_ON, 3 MIN_OFF.

Function
REQ-012 Duty conversion SHALL hold pending duty: pid_out >= 0 -> 0; pid_out < 0 -> min(255, |pid_out| >> 3), computed at 17-bit width so pid_out = -32768 saturates to 255.
REQ-013 duty_pend SHALL update on the edge where pid_valid=1 (visible next cycle); it SHALL capture regardless of enable.
REQ-014 Prescaler pre_cnt SHALL count 0..PRESCALE-1 and wrap; tick_cnt (8 bit) SHALL increment when pre_cnt wraps, giving a period of 256*PRESCALE cycles. Both counters run regardless of enable.
REQ-015 At a period boundary (pre_cnt=PRESCALE-1 and tick_cnt=255), tick_cnt SHALL wrap to 0 and duty_active SHALL load duty_pend. A pid_valid in that same cycle SHALL take effect at the following boundary.
REQ-016 pwm_req (internal, combinational) SHALL equal enable AND (tick_cnt < duty_active); duty 0 means never on, duty 255 means on for 255 of 256 ticks.
REQ-017 FSM transition IDLE_OFF -> MIN_ON when pwm_req=1; load timer = MIN_ON_CYC-1.
REQ-018 FSM transition MIN_ON -> RUN_ON when timer=0, otherwise decrement timer; pwm_req and enable are ignored in MIN_ON.
REQ-019 FSM transition RUN_ON -> MIN_OFF when pwm_req=0; load timer = MIN_OFF_CYC-1.
REQ-020 FSM transition MIN_OFF -> IDLE_OFF when timer=0, otherwise decrement timer; pwm_req is ignored in MIN_OFF.
REQ-021 comp_on SHALL be registered: 1 exactly while state is MIN_ON or RUN_ON.
REQ-022 Guaranteed behaviour: comp_on high for >= MIN_ON_CYC consecutive cycles per activation and low for >= MIN_OFF_CYC cycles after each deactivation.
REQ-023 Timer width SHALL be 16 bits, with no wrap below 0.
REQ-024 Dropping enable in RUN_ON SHALL give MIN_OFF on the next edge; dropping it in MIN_ON SHALL let min-on complete, then RUN_ON exits on the following edge.

Reset
REQ-025 On rst=1 at a posedge, the block SHALL set pre_cnt=0, tick_cnt=0, duty_pend=0, duty_active=0, timer=0, state=IDLE_OFF, comp_on=0.
REQ-026 Reset SHALL take precedence over pid_valid and over every FSM transition, including mid-MIN_ON and mid-MIN_OFF; min-off is not enforced after reset.

Verification
REQ-027 Duty map: pid_out = -512, +256, -2048, -32768 each with pid_valid -> duty after the next boundary = 64, 0, 255, 255.
REQ-028 PWM shape: enable=1, pid_out=-512, PRESCALE=4, MIN_ON_CYC=16, MIN_OFF_CYC=32 -> pwm_req high for 256 cycles per 1024-cycle period; comp_on high >= 256 cycles and low >= 32 cycles, repeating.
REQ-029 Min-on: duty=1 (pid_out=-8) -> pwm_req pulses 4 cycles, yet comp_on stays high exactly 17 cycles (16 in MIN_ON plus 1 in RUN_ON), then MIN_OFF for 32 cycles.
REQ-030 Boundary race: pid_valid with pid_out=-512 in the boundary cycle -> duty keeps its old value for that period and becomes 64 at the next boundary.
REQ-031 Enable drop: enable 1->0 in RUN_ON -> state=MIN_OFF next cycle, comp_on=0; enable 1->0 at MIN_ON timer=10 -> comp_on remains 1 for 11 more cycles in MIN_ON, plus 1 cycle in RUN_ON.
REQ-032 Reset mid-MIN_OFF with duty=255 -> all outputs 0 and state 0 the cycle after reset; comp_on stays 0 until duty_active is reloaded at a boundary.
